// File: rtl/mem_io_responder_pkg.sv
// Shared bus encodings, IO map and default sizing for the memory-side responder.
package mem_io_responder_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned RAM_ADDR_W_DEF  = 17;
    localparam int unsigned FIFO_DEPTH_DEF  = 8;
    localparam int unsigned FULL_MARGIN_DEF = 2;

    // IO window select bit and register addresses inside the window
    localparam int unsigned             IO_SEL_BIT   = 17;
    localparam int unsigned             IO_OFF_W     = 3;
    localparam logic [ADDR_W-1:0]       IO_TX_ADDR   = 32'h0003_0000;
    localparam logic [ADDR_W-1:0]       IO_CTRL_ADDR = 32'h0003_0004;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_rw_e;

    // Decoded view of one bus beat
    typedef struct packed {
        logic                io;
        logic [IO_OFF_W-1:0] off;
        logic                wr;
    } mem_dec_t;

    function automatic logic [IO_OFF_W-1:0] io_offset(input logic [ADDR_W-1:0] addr);
        return addr[IO_OFF_W-1:0];
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Memory-controller bus plus UART-side pins of the responder.
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic              iMEM_rw;
    logic [ADDR_W-1:0] iMEM_addr;
    logic [DATA_W-1:0] iMEM_dt;
    logic [DATA_W-1:0] oMEM_dt;
    logic              oIO_buffer_full;
    logic              oTX_valid;
    logic [DATA_W-1:0] oTX_dt;
    logic              iTX_ready;
    logic              iRX_valid;
    logic [DATA_W-1:0] iRX_dt;
    logic              oRX_ack;
    logic              oHalt;
    logic              oOverflow;

    modport slave (
        input  iMEM_rw, iMEM_addr, iMEM_dt, iTX_ready, iRX_valid, iRX_dt,
        output oMEM_dt, oIO_buffer_full, oTX_valid, oTX_dt, oRX_ack, oHalt, oOverflow
    );

    modport master (
        output iMEM_rw, iMEM_addr, iMEM_dt, iTX_ready, iRX_valid, iRX_dt,
        input  oMEM_dt, oIO_buffer_full, oTX_valid, oTX_dt, oRX_ack, oHalt, oOverflow
    );

endinterface

// File: rtl/mem_io_responder_tx_fifo.sv
// Synchronous FIFO for UART TX bytes; the caller guarantees no push when full
// (unless popping) and no pop when empty.
module mem_io_responder_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_dt_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [$clog2(DEPTH):0]       count_next_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live
    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            mem_q[wr_ptr_q] <= push_dt_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM with 1-cycle reads plus a small IO window
// (UART TX FIFO, RX byte port, halt/status register).
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W  = RAM_ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned FULL_MARGIN = FULL_MARGIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    mem_io_responder_if.slave  bus
);

    localparam int unsigned        CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]   FULL_LEVEL  = CNT_W'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [CNT_W-1:0]   DEPTH_LEVEL = CNT_W'(FIFO_DEPTH);
    localparam logic [IO_OFF_W-1:0] TX_OFF     = io_offset(IO_TX_ADDR);
    localparam logic [IO_OFF_W-1:0] CTRL_OFF   = io_offset(IO_CTRL_ADDR);

    logic [DATA_W-1:0]     ram_q [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_idx_c;
    mem_dec_t              dec_c;

    logic [DATA_W-1:0] mem_dt_q, mem_dt_d;
    logic              buf_full_q, buf_full_d;
    logic              halt_q, halt_d;
    logic              overflow_q, overflow_d;

    logic              tx_sel_c, ctrl_sel_c;
    logic              ram_we_c, push_req_c, push_c, pop_c;
    logic              fifo_full_c, fifo_nempty_c;
    logic [DATA_W-1:0] fifo_head_c;
    logic [CNT_W-1:0]  fifo_count_c, fifo_count_next_c;
    logic              addr_unused_c;

    // Upper address bits above the IO select bit are don't-care
    assign addr_unused_c = ^bus.iMEM_addr[ADDR_W-1:IO_SEL_BIT+1];

    // Bus beat decode
    always_comb begin
        dec_c     = '0;
        dec_c.io  = bus.iMEM_addr[IO_SEL_BIT];
        dec_c.off = io_offset(bus.iMEM_addr);
        dec_c.wr  = (bus.iMEM_rw == MEM_WRITE);
        ram_idx_c = bus.iMEM_addr[RAM_ADDR_W-1:0];
    end

    assign tx_sel_c      = dec_c.io && (dec_c.off == TX_OFF);
    assign ctrl_sel_c    = dec_c.io && (dec_c.off == CTRL_OFF);
    assign ram_we_c      = rdy && !dec_c.io && dec_c.wr;
    assign fifo_nempty_c = (fifo_count_c != '0);
    assign fifo_full_c   = (fifo_count_c == DEPTH_LEVEL);
    assign pop_c         = rdy && fifo_nempty_c && bus.iTX_ready;
    assign push_req_c    = rdy && tx_sel_c && dec_c.wr;
    // A push into a full FIFO is still accepted when the head leaves this cycle
    assign push_c        = push_req_c && (!fifo_full_c || pop_c);

    mem_io_responder_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_c),
        .push_dt_i    (bus.iMEM_dt),
        .pop_i        (pop_c),
        .head_o       (fifo_head_c),
        .count_o      (fifo_count_c),
        .count_next_o (fifo_count_next_c)
    );

    // Read data mux and sticky flag next-state
    always_comb begin
        mem_dt_d   = '0;
        halt_d     = halt_q;
        overflow_d = overflow_q;
        buf_full_d = (fifo_count_next_c >= FULL_LEVEL);
        if (!dec_c.wr) begin
            if (!dec_c.io) begin
                mem_dt_d = ram_q[ram_idx_c];
            end else if (tx_sel_c) begin
                mem_dt_d = bus.iRX_valid ? bus.iRX_dt : '0;
            end else if (ctrl_sel_c) begin
                mem_dt_d = {6'b0, overflow_q, fifo_nempty_c};
            end
        end
        if (ctrl_sel_c && dec_c.wr) begin
            halt_d = 1'b1;
        end
        if (push_req_c && fifo_full_c && !pop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Output registers; everything holds while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dt_q   <= '0;
            buf_full_q <= 1'b0;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (rdy) begin
            mem_dt_q   <= mem_dt_d;
            buf_full_q <= buf_full_d;
            halt_q     <= halt_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && ram_we_c) begin
            ram_q[ram_idx_c] <= bus.iMEM_dt;
        end
    end

    assign bus.oMEM_dt         = mem_dt_q;
    assign bus.oIO_buffer_full = buf_full_q;
    assign bus.oTX_valid       = fifo_nempty_c;
    assign bus.oTX_dt          = fifo_nempty_c ? fifo_head_c : '0;
    assign bus.oRX_ack         = !rst && rdy && tx_sel_c && !dec_c.wr && bus.iRX_valid;
    assign bus.oHalt           = halt_q;
    assign bus.oOverflow       = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scenario bench for mem_io_responder: read data is scoreboarded through a
// queue filled when the read address is driven and drained one cycle later.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    logic clk;
    logic rst;
    logic rdy;

    int unsigned errors;
    int unsigned checks;

    logic [7:0] rd_exp_q[$];
    logic [7:0] tx_model_q[$];

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [31:0] addr, input logic [7:0] dt);
        bus.iMEM_rw   = rw;
        bus.iMEM_addr = addr;
        bus.iMEM_dt   = dt;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0000_0000, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        bus.iTX_ready = 1'b0;
        bus.iRX_valid = 1'b0;
        bus.iRX_dt    = 8'h00;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.oMEM_dt !== 8'h00) begin errors++; $display("FAIL reset_mem_dt: got %h want 00", bus.oMEM_dt); end
        checks++; if (bus.oIO_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.oIO_buffer_full); end
        checks++; if (bus.oTX_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.oTX_valid); end
        checks++; if (bus.oTX_dt !== 8'h00) begin errors++; $display("FAIL reset_tx_dt: got %h want 00", bus.oTX_dt); end
        checks++; if (bus.oRX_ack !== 1'b0) begin errors++; $display("FAIL reset_rx_ack: got %b want 0", bus.oRX_ack); end
        checks++; if (bus.oHalt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", bus.oHalt); end
        checks++; if (bus.oOverflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.oOverflow); end
    endtask

    task automatic test_ram_rw();
        logic [7:0] exp;
        drive(1'b1, 32'h0000_0010, 8'hA5);
        tick();
        checks++; if (bus.oMEM_dt !== 8'h00) begin errors++; $display("FAIL ram_write_dt: got %h want 00", bus.oMEM_dt); end
        // read right after the write, then an alias with bit 18 set (bit 17 clear)
        drive(1'b0, 32'h0000_0010, 8'h00);
        rd_exp_q.push_back(8'hA5);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL ram_read_after_write: got %h want %h", bus.oMEM_dt, exp); end
        drive(1'b0, 32'h0004_0010, 8'h00);
        rd_exp_q.push_back(8'hA5);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL ram_read_alias: got %h want %h", bus.oMEM_dt, exp); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        logic [7:0] exp;
        vals[0] = 8'h13; vals[1] = 8'h05; vals[2] = 8'h00; vals[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0100 + 32'(i), vals[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0000_0100 + 32'(i), 8'h00);
            rd_exp_q.push_back(vals[i]);
            tick();
            exp = rd_exp_q.pop_front();
            checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL b2b_read[%0d]: got %h want %h", i, bus.oMEM_dt, exp); end
        end
        drive_idle();
    endtask

    task automatic test_tx_fifo();
        logic [7:0] msg [8];
        logic [7:0] exp;
        logic       exp_full;
        msg[0] = "H"; msg[1] = "i"; msg[2] = ","; msg[3] = " ";
        msg[4] = "S"; msg[5] = "o"; msg[6] = "C"; msg[7] = "!";
        bus.iTX_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, IO_TX_ADDR, msg[i]);
            tick();
            tx_model_q.push_back(msg[i]);
            exp_full = (i + 1 >= 6);
            checks++; if (bus.oIO_buffer_full !== exp_full) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i + 1, bus.oIO_buffer_full, exp_full); end
        end
        checks++; if (bus.oTX_valid !== 1'b1) begin errors++; $display("FAIL fill_tx_valid: got %b want 1", bus.oTX_valid); end
        checks++; if (bus.oTX_dt !== tx_model_q[0]) begin errors++; $display("FAIL fill_head: got %h want %h", bus.oTX_dt, tx_model_q[0]); end
        // push and pop together while full
        bus.iTX_ready = 1'b1;
        drive(1'b1, IO_TX_ADDR, 8'h41);
        tick();
        bus.iTX_ready = 1'b0;
        drive_idle();
        void'(tx_model_q.pop_front());
        tx_model_q.push_back(8'h41);
        checks++; if (bus.oOverflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b want 0", bus.oOverflow); end
        checks++; if (bus.oIO_buffer_full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b want 1", bus.oIO_buffer_full); end
        checks++; if (bus.oTX_dt !== tx_model_q[0]) begin errors++; $display("FAIL pushpop_head: got %h want %h", bus.oTX_dt, tx_model_q[0]); end
        // ninth byte into a full FIFO is dropped
        drive(1'b1, IO_TX_ADDR, 8'hEE);
        tick();
        checks++; if (bus.oOverflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", bus.oOverflow); end
        drive(1'b0, IO_CTRL_ADDR, 8'h00);
        rd_exp_q.push_back(8'h03);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL status_full: got %h want %h", bus.oMEM_dt, exp); end
        // drain
        drive_idle();
        bus.iTX_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            exp = tx_model_q.pop_front();
            checks++; if (bus.oTX_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", k, bus.oTX_valid); end
            checks++; if (bus.oTX_dt !== exp) begin errors++; $display("FAIL drain_dt[%0d]: got %h want %h", k, bus.oTX_dt, exp); end
            tick();
            exp_full = ((8 - k) >= 6);
            checks++; if (bus.oIO_buffer_full !== exp_full) begin errors++; $display("FAIL drain_full[%0d]: got %b want %b", k, bus.oIO_buffer_full, exp_full); end
        end
        checks++; if (bus.oTX_valid !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b want 0", bus.oTX_valid); end
        bus.iTX_ready = 1'b0;
        drive(1'b0, IO_CTRL_ADDR, 8'h00);
        rd_exp_q.push_back(8'h02);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL status_empty: got %h want %h", bus.oMEM_dt, exp); end
        drive_idle();
    endtask

    task automatic test_rx();
        logic [7:0] exp;
        bus.iRX_valid = 1'b1;
        bus.iRX_dt    = 8'h37;
        drive(1'b0, IO_TX_ADDR, 8'h00);
        rd_exp_q.push_back(8'h37);
        #1;
        checks++; if (bus.oRX_ack !== 1'b1) begin errors++; $display("FAIL rx_ack_pulse: got %b want 1", bus.oRX_ack); end
        tick();
        drive_idle();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL rx_data: got %h want %h", bus.oMEM_dt, exp); end
        #1;
        checks++; if (bus.oRX_ack !== 1'b0) begin errors++; $display("FAIL rx_ack_end: got %b want 0", bus.oRX_ack); end
        // unmapped offset reads zero and never acknowledges
        drive(1'b0, 32'h0003_0002, 8'h00);
        rd_exp_q.push_back(8'h00);
        #1;
        checks++; if (bus.oRX_ack !== 1'b0) begin errors++; $display("FAIL rx_ack_other_off: got %b want 0", bus.oRX_ack); end
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL other_off_read: got %h want %h", bus.oMEM_dt, exp); end
        bus.iRX_valid = 1'b0;
        drive(1'b0, IO_TX_ADDR, 8'h00);
        rd_exp_q.push_back(8'h00);
        #1;
        checks++; if (bus.oRX_ack !== 1'b0) begin errors++; $display("FAIL rx_no_ack: got %b want 0", bus.oRX_ack); end
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL rx_empty_data: got %h want %h", bus.oMEM_dt, exp); end
        drive_idle();
    endtask

    task automatic test_halt();
        drive(1'b1, IO_CTRL_ADDR, 8'h00);
        tick();
        drive_idle();
        checks++; if (bus.oHalt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", bus.oHalt); end
        tick();
        checks++; if (bus.oHalt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", bus.oHalt); end
    endtask

    task automatic test_reset_mid();
        bus.iTX_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, IO_TX_ADDR, 8'h60 + 8'(i));
            tick();
        end
        checks++; if (bus.oTX_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", bus.oTX_valid); end
        rst = 1'b1;
        drive(1'b0, 32'h0000_0010, 8'h00);
        tick();
        checks++; if (bus.oTX_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.oTX_valid); end
        checks++; if (bus.oHalt !== 1'b0) begin errors++; $display("FAIL rst_mid_halt: got %b want 0", bus.oHalt); end
        checks++; if (bus.oMEM_dt !== 8'h00) begin errors++; $display("FAIL rst_mid_mem_dt: got %h want 00", bus.oMEM_dt); end
        checks++; if (bus.oTX_dt !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_dt: got %h want 00", bus.oTX_dt); end
        rst = 1'b0;
        drive_idle();
        tick();
        checks++; if (bus.oTX_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", bus.oTX_valid); end
    endtask

    task automatic test_rdy_hold();
        logic [7:0] exp;
        drive(1'b0, 32'h0000_0010, 8'h00);
        rd_exp_q.push_back(8'hA5);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL hold_pre_read: got %h want %h", bus.oMEM_dt, exp); end
        rdy = 1'b0;
        drive(1'b1, 32'h0000_0010, 8'h5A);
        tick();
        checks++; if (bus.oMEM_dt !== 8'hA5) begin errors++; $display("FAIL hold_mem_dt: got %h want a5", bus.oMEM_dt); end
        drive(1'b1, IO_TX_ADDR, 8'h77);
        tick();
        checks++; if (bus.oTX_valid !== 1'b0) begin errors++; $display("FAIL hold_no_push: got %b want 0", bus.oTX_valid); end
        drive(1'b1, IO_CTRL_ADDR, 8'h00);
        tick();
        checks++; if (bus.oHalt !== 1'b0) begin errors++; $display("FAIL hold_no_halt: got %b want 0", bus.oHalt); end
        bus.iRX_valid = 1'b1;
        bus.iRX_dt    = 8'h44;
        drive(1'b0, IO_TX_ADDR, 8'h00);
        #1;
        checks++; if (bus.oRX_ack !== 1'b0) begin errors++; $display("FAIL hold_no_ack: got %b want 0", bus.oRX_ack); end
        tick();
        bus.iRX_valid = 1'b0;
        rdy = 1'b1;
        drive(1'b0, 32'h0000_0010, 8'h00);
        rd_exp_q.push_back(8'hA5);
        tick();
        exp = rd_exp_q.pop_front();
        checks++; if (bus.oMEM_dt !== exp) begin errors++; $display("FAIL hold_ram_unchanged: got %h want %h", bus.oMEM_dt, exp); end
        drive_idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_tx_fifo();
        test_rx();
        test_halt();
        test_reset_mid();
        test_rdy_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
